// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the line-burst data memory.
//   - state_t : transaction FSM states (IDLE, WAIT, XFER, DONE)
//   - STATE_W : width of the encoded state (also the debug state port width)
//   - beat_w(): width of a beat counter for a given line size
package dmem_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      XFER = 2'd2,
      DONE = 2'd3
   } state_t;

   // Beat counter width; a one-word line would still need a 1-bit counter.
   function automatic int beat_w(input int line_words);
      return (line_words > 1) ? $clog2(line_words) : 1;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: word-addressed storage, synchronous write, registered read.
// Storage is never reset, so contents survive a reset of the surrounding logic.
// Optional macro DMEM_BYTE_EN_EN adds a per-byte write mask.
// Ports:
//   CLK    in   clock, rising edge
//   we     in   write enable for addr this cycle
//   addr   in   word address (shared by read and write)
//   wdata  in   write data
//   be     in   per-byte write mask (only with DMEM_BYTE_EN_EN)
//   rdata  out  mem[addr] registered on every rising edge
module dmem_array #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10
) (
   input  logic              CLK,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
`ifdef DMEM_BYTE_EN_EN
   input  logic [DATA_W/8-1:0] be,
`endif
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge CLK) begin
      if (we) begin
`ifdef DMEM_BYTE_EN_EN
         for (int i = 0; i < DATA_W/8; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
`else
         mem[addr] <= wdata;
`endif
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/data_memory_line.sv
// data_memory_line: line-burst backing store for the data cache refill and
// writeback path. One line request is accepted per transaction; after LATENCY
// idle cycles LINE_WORDS consecutive words are streamed out (read) or taken in
// (write, paced by wd_valid).
// Optional macro DMEM_BYTE_EN_EN adds the wd_be per-byte write mask.
//
// Handshakes: req is transferred on a rising edge where req_valid && req_ready;
// a write beat is transferred on a rising edge where wd_valid && wd_ready.
// Read beats (rd_valid) have no back-pressure.
//
// Ports:
//   CLK, RST              clock; asynchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_we, req_addr      line write/read select, word address (low bits ignored)
//   wd_valid/wd_ready     write beat handshake
//   wd_data, wd_be        write beat data, byte mask (wd_be only with macro)
//   rd_valid, rd_data     read beat and its data (data forced to 0 when invalid)
//   rd_last               final read beat of the line
//   done                  one-cycle pulse when the transaction completes
//   dbg_state             current FSM state
module data_memory_line
   import dmem_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 10,
   parameter int LINE_WORDS = 4,
   parameter int LATENCY    = 3
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_we,
   input  logic [ADDR_W-1:0]  req_addr,
   input  logic               wd_valid,
   output logic               wd_ready,
   input  logic [DATA_W-1:0]  wd_data,
`ifdef DMEM_BYTE_EN_EN
   input  logic [DATA_W/8-1:0] wd_be,
`endif
   output logic               rd_valid,
   output logic [DATA_W-1:0]  rd_data,
   output logic               rd_last,
   output logic               done,
   output logic [STATE_W-1:0] dbg_state
);

   localparam int BEAT_W = beat_w(LINE_WORDS);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
   localparam logic [3:0]        WAIT_LAST = 4'(LATENCY > 0 ? LATENCY - 1 : 0);
   localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS - 1);

   state_t             state, next_state;
   logic [BEAT_W-1:0]  beat;
   logic [3:0]         wait_cnt;
   logic [ADDR_W-1:0]  base;
   logic               we_q;
   logic               accept;
   logic               wr_hs;
   logic               beat_inc;
   logic [DATA_W-1:0]  arr_rdata;

   assign dbg_state = state;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      req_ready  = 1'b0;
      wd_ready   = 1'b0;
      done       = 1'b0;
      accept     = 1'b0;
      wr_hs      = 1'b0;
      beat_inc   = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept     = 1'b1;
               next_state = (LATENCY > 0) ? WAIT : XFER;
            end
         end
         WAIT: begin
            if (wait_cnt == WAIT_LAST) next_state = XFER;
         end
         XFER: begin
            if (we_q) begin
               // Write beats advance only on a handshake; stalls are unbounded.
               wd_ready = 1'b1;
               if (wd_valid) begin
                  wr_hs    = 1'b1;
                  beat_inc = 1'b1;
                  if (beat == LAST_BEAT) next_state = DONE;
               end
            end else begin
               beat_inc = 1'b1;
               if (beat == LAST_BEAT) next_state = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         beat     <= '0;
         wait_cnt <= '0;
         base     <= '0;
         we_q     <= 1'b0;
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
      end else begin
         if (accept) begin
            // Lines are aligned, so base+beat never carries out of the line.
            base     <= req_addr & ~LINE_MASK;
            we_q     <= req_we;
            beat     <= '0;
            wait_cnt <= '0;
         end
         if (state == WAIT) wait_cnt <= wait_cnt + 4'd1;
         if (beat_inc)      beat     <= beat + BEAT_W'(1);
         // Read beats line up with the array's registered read of base+beat.
         rd_valid <= (state == XFER) && !we_q;
         rd_last  <= (state == XFER) && !we_q && (beat == LAST_BEAT);
      end
   end

   dmem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_array (
      .CLK   (CLK),
      .we    (wr_hs),
      .addr  (base | ADDR_W'(beat)),
      .wdata (wd_data),
`ifdef DMEM_BYTE_EN_EN
      .be    (wd_be),
`endif
      .rdata (arr_rdata)
   );

   // The array output register is not reset; gate it so rd_data is 0 when idle.
   assign rd_data = rd_valid ? arr_rdata : '0;

endmodule

// File: tb/tb_data_memory_line.sv
// Bench for data_memory_line: two instances (LATENCY=3 and LATENCY=0) share
// the stimulus; sel routes requests to one of them and selects its outputs.
module tb_data_memory_line;
   import dmem_pkg::*;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   always #5 CLK = ~CLK;

   logic        sel = 1'b0;
   logic        req_valid = 1'b0, req_we = 1'b0, wd_valid = 1'b0;
   logic [9:0]  req_addr = '0;
   logic [31:0] wd_data = '0;
   logic [3:0]  wd_be = 4'hF;

   logic rr3, wr3, rv3, rl3, dn3, rr0, wr0, rv0, rl0, dn0;
   logic [31:0] rd3, rd0;
   logic [1:0]  st3, st0;

   logic req_ready, wd_ready, rd_valid, rd_last, done;
   logic [31:0] rd_data;
   logic [1:0]  dbg_state;
   assign req_ready = sel ? rr0 : rr3;
   assign wd_ready  = sel ? wr0 : wr3;
   assign rd_valid  = sel ? rv0 : rv3;
   assign rd_last   = sel ? rl0 : rl3;
   assign done      = sel ? dn0 : dn3;
   assign rd_data   = sel ? rd0 : rd3;
   assign dbg_state = sel ? st0 : st3;

   data_memory_line #(.LATENCY(3)) dut3 (
      .CLK(CLK), .RST(RST),
      .req_valid(req_valid & ~sel), .req_ready(rr3), .req_we(req_we), .req_addr(req_addr),
      .wd_valid(wd_valid & ~sel), .wd_ready(wr3), .wd_data(wd_data),
`ifdef DMEM_BYTE_EN_EN
      .wd_be(wd_be),
`endif
      .rd_valid(rv3), .rd_data(rd3), .rd_last(rl3), .done(dn3), .dbg_state(st3)
   );

   data_memory_line #(.LATENCY(0)) dut0 (
      .CLK(CLK), .RST(RST),
      .req_valid(req_valid & sel), .req_ready(rr0), .req_we(req_we), .req_addr(req_addr),
      .wd_valid(wd_valid & sel), .wd_ready(wr0), .wd_data(wd_data),
`ifdef DMEM_BYTE_EN_EN
      .wd_be(wd_be),
`endif
      .rd_valid(rv0), .rd_data(rd0), .rd_last(rl0), .done(dn0), .dbg_state(st0)
   );

   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] exp_q [$];
   logic [31:0] model_mem [2][1024];

   // ---------------- driver / scoreboard tasks ----------------
   task automatic run_write(input logic [9:0] a, input logic [31:0] d [4],
                            input int gap, input logic [3:0] be);
      int b = 0;
      int t = 0;
      logic early_done = 1'b0;
      logic [9:0] base = {a[9:2], 2'b00};
      int s = int'(sel);
      @(negedge CLK);
      req_valid = 1'b1; req_we = 1'b1; req_addr = a;
      while (!req_ready && t < 20) begin @(negedge CLK); t++; end
      @(negedge CLK);
      req_valid = 1'b0;
      while (b < 4 && t < 200) begin
         wd_valid = 1'b1; wd_data = d[b]; wd_be = be;
         if (done) early_done = 1'b1;
         if (wd_ready) begin
            for (int i = 0; i < 4; i++)
               if (be[i]) model_mem[s][base + 10'(b)][8*i +: 8] = d[b][8*i +: 8];
            b++;
            @(negedge CLK); t++;
            wd_valid = 1'b0;
            if (b < 4) repeat (gap) begin
               if (done) early_done = 1'b1;
               @(negedge CLK); t++;
            end
         end else begin
            @(negedge CLK); t++;
         end
      end
      wd_valid = 1'b0;
      n_checks++;
      if (b !== 4) $display("FAIL write_beats @%h: got %0d required 4", a, b);
      else n_pass++;
      n_checks++;
      if (early_done !== 1'b0) $display("FAIL write_early_done @%h: got 1 required 0", a);
      else n_pass++;
      n_checks++;
      if (done !== 1'b1) $display("FAIL write_done_after_last @%h: got %b required 1", a, done);
      else n_pass++;
      @(negedge CLK);
      n_checks++;
      if (done !== 1'b0 || req_ready !== 1'b1)
         $display("FAIL write_return_idle @%h: got done=%b ready=%b required 0/1", a, done, req_ready);
      else n_pass++;
   endtask

   task automatic run_read(input logic [9:0] a, input int lat);
      int t = 0, beats = 0, ndone = 0, first = -1;
      logic gap_err = 1'b0, last_err = 1'b0;
      logic [31:0] exp;
      logic [9:0] base = {a[9:2], 2'b00};
      int s = int'(sel);
      for (int i = 0; i < 4; i++) exp_q.push_back(model_mem[s][base + 10'(i)]);
      @(negedge CLK);
      req_valid = 1'b1; req_we = 1'b0; req_addr = a;
      // stray write beats during a read must not touch memory
      wd_valid = 1'b1; wd_data = 32'hBAD0_0000;
      while (!req_ready && t < 20) begin @(negedge CLK); t++; end
      @(negedge CLK);
      req_valid = 1'b0;
      for (int cyc = 0; cyc < lat + 10; cyc++) begin
         if (rd_valid) begin
            if (first < 0) first = cyc;
            else if (cyc != first + beats) gap_err = 1'b1;
            if (rd_last !== (beats == 3)) last_err = 1'b1;
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            n_checks++;
            if (rd_data !== exp)
               $display("FAIL read_data @%h beat %0d: got %h required %h", base, beats, rd_data, exp);
            else n_pass++;
            beats++;
         end
         if (done) ndone++;
         @(negedge CLK);
      end
      wd_valid = 1'b0;
      n_checks++;
      if (first !== lat + 1) $display("FAIL read_latency @%h: got %0d required %0d", a, first, lat + 1);
      else n_pass++;
      n_checks++;
      if (beats !== 4 || gap_err) $display("FAIL read_beats @%h: got %0d gap=%b required 4 contiguous", a, beats, gap_err);
      else n_pass++;
      n_checks++;
      if (last_err) $display("FAIL read_last @%h: rd_last misplaced, required on beat 3 only", a);
      else n_pass++;
      n_checks++;
      if (ndone !== 1) $display("FAIL read_done_count @%h: got %0d required 1", a, ndone);
      else n_pass++;
      exp_q.delete();
   endtask

   // ---------------- scenarios ----------------
   task automatic check_idle_outputs(input string nm);
      n_checks++;
      if (req_ready !== 1'b1) $display("FAIL %s_req_ready: got %b required 1", nm, req_ready); else n_pass++;
      n_checks++;
      if (rd_valid !== 1'b0 || rd_last !== 1'b0) $display("FAIL %s_rd_flags: got %b%b required 00", nm, rd_valid, rd_last); else n_pass++;
      n_checks++;
      if (rd_data !== 32'h0) $display("FAIL %s_rd_data: got %h required 0", nm, rd_data); else n_pass++;
      n_checks++;
      if (done !== 1'b0 || wd_ready !== 1'b0) $display("FAIL %s_done_wdready: got %b%b required 00", nm, done, wd_ready); else n_pass++;
      n_checks++;
      if (dbg_state !== IDLE) $display("FAIL %s_state: got %0d required %0d", nm, dbg_state, IDLE); else n_pass++;
   endtask

   task automatic test_reset();
      #2 RST = 1'b1;
      #1 check_idle_outputs("reset");
      @(negedge CLK); @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic test_line_write_read();
      logic [31:0] d [4];
      d = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
      run_write(10'h013, d, 0, 4'hF);
      run_read(10'h010, 3);
   endtask

   task automatic test_write_stalls();
      logic [31:0] d [4];
      d = '{32'hB0B0_0000, 32'hB0B0_1111, 32'hB0B0_2222, 32'hB0B0_3333};
      run_write(10'h020, d, 2, 4'hF);
      run_read(10'h020, 3);
   endtask

   task automatic test_busy_request();
      int t = 0, beats = 0, ndone = 0, dn_cyc = -1;
      logic ready_early = 1'b0, ready_after = 1'b0;
      logic [31:0] exp;
      for (int i = 0; i < 4; i++) exp_q.push_back(model_mem[0][10'h010 + 10'(i)]);
      for (int i = 0; i < 4; i++) exp_q.push_back(model_mem[0][10'h020 + 10'(i)]);
      @(negedge CLK);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h010;
      while (!req_ready && t < 20) begin @(negedge CLK); t++; end
      @(negedge CLK);
      req_addr = 10'h022;   // held request for another line while busy
      for (int c = 0; c < 30; c++) begin
         if (dn_cyc < 0 && req_ready) ready_early = 1'b1;
         if (dn_cyc >= 0 && c == dn_cyc + 1) ready_after = req_ready;
         if (dn_cyc >= 0 && c == dn_cyc + 2) req_valid = 1'b0;
         if (rd_valid) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            n_checks++;
            if (rd_data !== exp) $display("FAIL busy_data beat %0d: got %h required %h", beats, rd_data, exp);
            else n_pass++;
            beats++;
         end
         if (done) begin ndone++; if (dn_cyc < 0) dn_cyc = c; end
         @(negedge CLK);
      end
      req_valid = 1'b0;
      n_checks++;
      if (ready_early) $display("FAIL busy_ready_early: got 1 required 0 before done"); else n_pass++;
      n_checks++;
      if (ready_after !== 1'b1) $display("FAIL busy_ready_after_done: got %b required 1", ready_after); else n_pass++;
      n_checks++;
      if (beats !== 8 || ndone !== 2) $display("FAIL busy_counts: got beats=%0d done=%0d required 8/2", beats, ndone); else n_pass++;
      exp_q.delete();
   endtask

   task automatic test_reset_mid_burst();
      logic [31:0] d [4];
      int b = 0, t = 0;
      logic saw_done = 1'b0;
      d = '{32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003};
      run_write(10'h040, d, 0, 4'hF);
      @(negedge CLK);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h040;
      while (!req_ready && t < 20) begin @(negedge CLK); t++; end
      @(negedge CLK);
      req_valid = 1'b0;
      while (b < 2 && t < 50) begin
         wd_valid = 1'b1; wd_data = (b == 0) ? 32'd7 : 32'd8; wd_be = 4'hF;
         if (wd_ready) b++;
         @(negedge CLK); t++;
      end
      wd_valid = 1'b0;
      model_mem[0][10'h040] = 32'd7;
      model_mem[0][10'h041] = 32'd8;
      RST = 1'b1;
      #1 check_idle_outputs("midreset");
      repeat (2) begin @(negedge CLK); if (done) saw_done = 1'b1; end
      RST = 1'b0;
      repeat (2) begin @(negedge CLK); if (done) saw_done = 1'b1; end
      n_checks++;
      if (saw_done) $display("FAIL midreset_no_done: got done pulse required none"); else n_pass++;
      run_read(10'h040, 3);
   endtask

   task automatic test_latency0_top_line();
      logic [31:0] d [4];
      sel = 1'b1;
      d = '{32'h5555_0000, 32'h5555_0001, 32'h5555_0002, 32'h5555_0003};
      run_write(10'h000, d, 0, 4'hF);
      d = '{32'd1, 32'd2, 32'd3, 32'd4};
      run_write(10'h3FE, d, 1, 4'hF);
      run_read(10'h3FC, 0);
      run_read(10'h000, 0);
      sel = 1'b0;
   endtask

`ifdef DMEM_BYTE_EN_EN
   task automatic test_byte_enable();
      logic [31:0] d [4];
      d = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      run_write(10'h050, d, 0, 4'hF);
      d = '{32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678};
      run_write(10'h050, d, 0, 4'b0101);
      run_read(10'h050, 3);
   endtask
`endif

   initial begin
      test_reset();
      test_line_write_read();
      test_write_stalls();
      test_busy_request();
      test_reset_mid_burst();
      test_latency0_top_line();
`ifdef DMEM_BYTE_EN_EN
      test_byte_enable();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete, %0d/%0d passed so far", n_pass, n_checks);
      $fatal(1, "timeout");
   end

endmodule
